// File: rtl/clk_divider_prog.sv
// Programmable even-ratio clock divider: out = in / (2*(div+1)), 50% duty, glitch-free ratio changes.
// Optional period counter on the 'cycles' port is built when CLKDIV_PERIOD_CNT_EN is defined.
module clk_divider_prog #(
    parameter int DIV_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             in,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             out,
    output logic             rise_pulse,
    output logic             pend
`ifdef CLKDIV_PERIOD_CNT_EN
    ,
    output logic [CNT_W-1:0] cycles
`endif
);

    if (DIV_W < 1 || CNT_W < 1) begin : g_bad_param
        $error("clk_divider_prog: DIV_W and CNT_W must be at least 1");
    end

    logic [DIV_W-1:0] act_div_q, act_div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             out_q, out_d;
    logic             rise_q, rise_d;
    logic             pend_q, pend_d;
    logic             at_end;

    always_comb begin
        at_end    = (cnt_q == act_div_q);
        act_div_d = act_div_q;
        cnt_d     = cnt_q;
        out_d     = out_q;
        rise_d    = en & at_end & ~out_q;
        pend_d    = (div != act_div_q);
        if (en) begin
            if (at_end) begin
                cnt_d = '0;
                out_d = ~out_q;
                // Only the end of a high phase may take a new ratio, so no phase is ever cut short.
                if (out_q) begin
                    act_div_d = div;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (!out_q && (div != act_div_q)) begin
            // Stopped while low: restart the low phase cleanly with the new ratio.
            act_div_d = div;
            cnt_d     = '0;
        end
    end

    always_ff @(posedge in) begin
        if (rst) begin
            act_div_q <= div;
            cnt_q     <= '0;
            out_q     <= 1'b0;
            rise_q    <= 1'b0;
            pend_q    <= 1'b0;
        end else begin
            act_div_q <= act_div_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            rise_q    <= rise_d;
            pend_q    <= pend_d;
        end
    end

    assign out        = out_q;
    assign rise_pulse = rise_q;
    assign pend       = pend_q;

`ifdef CLKDIV_PERIOD_CNT_EN
    logic [CNT_W-1:0] cycles_q, cycles_d;

    always_comb begin
        cycles_d = cycles_q + CNT_W'(rise_q);
    end

    always_ff @(posedge in) begin
        if (rst) begin
            cycles_q <= '0;
        end else begin
            cycles_q <= cycles_d;
        end
    end

    assign cycles = cycles_q;
`endif

endmodule
